vector_mem_unit: RTL and testbench
==================================

# vector_mem_unit

Multi-cycle vector/scalar memory-access unit in the MEM stage of the vector processor. It is the parametrised successor of the single-beat vector load/store path. A V-bit vector is split into E = V/N elements and moved over a word-wide memory port one element per cycle, at a configurable element stride. The CPU pipeline is stalled until the transfer completes. Scalar accesses pass straight through without stalling.

## Interface
- V, default 128: vector register width in bits; must be an integer multiple of N.
- N, default 32: scalar word / memory data width and word-address width.
- E (localparam), V/N: element count; must be ≥ 2.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous and active-low.
- req  in  1  MEM-stage memory instruction present.
- is_vector  in  1  1 = vector access, 0 = scalar access.
- mem_wen  in  1  1 = store, 0 = load.
- address  in  N  word address (scalar address, or vector base address).
- stride  in  N  element stride in words, unsigned.
- input_data  in  N  scalar store data.
- input_vector  in  V  vector store data; element i occupies bits [i*N +: N].
- mem_rdata  in  N  memory read data, valid one cycle after the address is issued.
- stall_cpu  out  1  holds the pipeline.
- m_address  out  N  memory word address.
- m_wen  out  1  memory write enable.
- m_wdata  out  N  memory write data.
- output_data  out  N  scalar load result (= mem_rdata).
- output_vector  out  V  vector load result register.
- vec_done  out  1  one-cycle pulse marking the last cycle of a vector operation.

## Operation
- States: IDLE, STORE, LOAD, DRAIN, DONE. Element counter idx spans 0..E-1.
- **Scalar access** (req & !is_vector in IDLE), purely combinational:
  - m_address = address, m_wen = mem_wen, m_wdata = input_data.
  - stall_cpu = 0.
- **Vector acceptance**: at the IDLE edge where req & is_vector = 1:
  - capture base = address, stride, and vbuf = input_vector;
  - set idx = 0;
  - go to STORE if mem_wen, else LOAD.
- **Element address**: elem_addr(i) = base + i*stride, modulo 2^N (wraps silently).
- **STORE**, each cycle:
  - m_wen = 1, m_address = elem_addr(idx), m_wdata = vbuf lane idx;
  - idx increments; after idx = E-1, go to DONE.
- **LOAD**, each cycle:
  - m_wen = 0, m_address = elem_addr(idx);
  - if idx ≥ 1, write mem_rdata into output_vector lane idx-1;
  - after idx = E-1, go to DRAIN.
- **DRAIN**: write mem_rdata into lane E-1; m_wen = 0; go to DONE.
- **DONE**: vec_done = 1, stall_cpu = 0, m_wen = 0; go unconditionally to IDLE. req is ignored here, because it still belongs to the finishing instruction.
- **stall_cpu** = (IDLE & req & is_vector) | STORE | LOAD | DRAIN.
- output_vector lanes update progressively. The result is complete and stable from DONE onward and is held until the next vector load overwrites it.
- **Stride 0**:
  - load broadcasts the word at base to all lanes;
  - store writes base E times, and lane E-1 is the final value.

## Timing
- Vector store: stall is high for 1 + E cycles (request cycle + STORE); DONE is the next cycle.
- Vector load: stall is high for E + 2 cycles (request + LOAD×E + DRAIN); DONE is the next cycle.
- Memory writes occur on the E consecutive STORE cycles; no gaps are allowed.
- Back-to-back vector operations: the next request is accepted in IDLE, one cycle after DONE.
- Reset (rst = 0, asynchronous, at any time including mid-transfer):
  - state = IDLE, idx = 0, output_vector = 0, vbuf = 0, base = 0, stride = 0, vec_done = 0;
  - m_wen is driven 0 immediately, and no further element accesses are issued;
  - a partially loaded vector is discarded.
- Outputs during reset with req = 0: stall_cpu = 0, m_address = address, m_wdata = input_data.

## Test plan
- **Unit-stride load**:
  - stimulus: mem[0x10..0x13] = 0x11,0x22,0x33,0x44; load base 0x10, stride 1, V=128;
  - required: stall high 6 cycles; output_vector = 0x00000044_00000033_00000022_00000011; vec_done pulses once.
- **Stride-2 store**:
  - stimulus: input_vector = {0xD,0xC,0xB,0xA}, base 0x20;
  - required: writes at 0x20, 0x22, 0x24, 0x26 of 0xA..0xD on 4 consecutive cycles; stall high 5 cycles.
- **Stride-0 broadcast and wrap**:
  - stimulus: load base 0x40 stride 0 with mem[0x40] = 0x5A;
  - required: all lanes = 0x5A.
  - stimulus: store base 0xFFFFFFFE stride 1;
  - required: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- **Scalar pass-through**:
  - stimulus: scalar store to 0x8 with data 0x1234, then scalar load from 0x8;
  - required: stall_cpu stays 0; m_wen = 1 for one cycle; output_data = 0x1234 one cycle after the load address.
- **Reset mid-load**:
  - stimulus: rst = 0 after 2 LOAD cycles;
  - required: immediate IDLE; output_vector = 0; stall_cpu = 0; m_wen = 0; no later accesses. A subsequent load completes normally.
- **Back-to-back**:
  - stimulus: store followed by load of the same base with req held through DONE;
  - required: exactly one acceptance per instruction; the load returns the stored vector.

Source files
------------

// File: rtl/vector_mem_unit.sv
// rtl/vector_mem_unit.sv - multi-cycle vector/scalar memory access unit for the MEM stage
module vector_mem_unit #(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         is_vector,
  input  logic         mem_wen,
  input  logic [N-1:0] address,
  input  logic [N-1:0] stride,
  input  logic [N-1:0] input_data,
  input  logic [V-1:0] input_vector,
  input  logic [N-1:0] mem_rdata,
  output logic         stall_cpu,
  output logic [N-1:0] m_address,
  output logic         m_wen,
  output logic [N-1:0] m_wdata,
  output logic [N-1:0] output_data,
  output logic [V-1:0] output_vector,
  output logic         vec_done
);

  localparam int E  = V / N;
  localparam int IW = $clog2(E);
  localparam logic [IW-1:0] LAST = IW'(E - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic [IW-1:0] lane;
  logic [N-1:0]  elem_addr;
  logic [N-1:0]  stride_q;
  logic [V-1:0]  vbuf;
  logic          accept;
  logic          last;

  assign accept      = (state == S_IDLE) && req && is_vector;
  assign last        = (idx == LAST);
  // Load data lags the issued address by one cycle, so it lands in the previous lane.
  assign lane        = idx - IW'(1);
  assign output_data = mem_rdata;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; DONE ignores req since it still belongs to the finishing instruction
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = mem_wen ? S_STORE : S_LOAD;
      S_STORE: if (last) state_nx = S_DONE;
      S_LOAD:  if (last) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory port, stall and completion outputs; scalar accesses pass straight through in IDLE
  always_comb begin
    stall_cpu = 1'b0;
    m_address = address;
    m_wen     = 1'b0;
    m_wdata   = input_data;
    vec_done  = 1'b0;
    case (state)
      S_IDLE: begin
        stall_cpu = req && is_vector;
        m_wen     = rst && req && !is_vector && mem_wen;
      end
      S_STORE: begin
        stall_cpu = 1'b1;
        m_wen     = 1'b1;
        m_address = elem_addr;
        m_wdata   = vbuf[idx*N +: N];
      end
      S_LOAD: begin
        stall_cpu = 1'b1;
        m_address = elem_addr;
      end
      S_DRAIN: begin
        stall_cpu = 1'b1;
        m_address = elem_addr;
      end
      S_DONE: begin
        vec_done  = 1'b1;
        m_address = elem_addr;
      end
      default: ;
    endcase
  end

  // Element datapath: running element address, lane counter, store buffer and load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx           <= '0;
      elem_addr     <= '0;
      stride_q      <= '0;
      vbuf          <= '0;
      output_vector <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx       <= '0;
            elem_addr <= address;
            stride_q  <= stride;
            vbuf      <= input_vector;
          end
        end
        S_STORE: begin
          idx       <= idx + IW'(1);
          elem_addr <= elem_addr + stride_q;
        end
        S_LOAD: begin
          if (idx != '0) output_vector[lane*N +: N] <= mem_rdata;
          idx       <= idx + IW'(1);
          elem_addr <= elem_addr + stride_q;
        end
        S_DRAIN: output_vector[(E-1)*N +: N] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// tb/tb_vector_mem_unit.sv - directed self-checking bench for vector_mem_unit
module tb_vector_mem_unit;

  logic         clk;
  logic         rst;
  logic         req;
  logic         is_vector;
  logic         mem_wen;
  logic [31:0]  address;
  logic [31:0]  stride;
  logic [31:0]  input_data;
  logic [127:0] input_vector;
  logic [31:0]  mem_rdata;
  logic         stall_cpu;
  logic [31:0]  m_address;
  logic         m_wen;
  logic [31:0]  m_wdata;
  logic [31:0]  output_data;
  logic [127:0] output_vector;
  logic         vec_done;

  vector_mem_unit #(.V(128), .N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .is_vector     (is_vector),
    .mem_wen       (mem_wen),
    .address       (address),
    .stride        (stride),
    .input_data    (input_data),
    .input_vector  (input_vector),
    .mem_rdata     (mem_rdata),
    .stall_cpu     (stall_cpu),
    .m_address     (m_address),
    .m_wen         (m_wen),
    .m_wdata       (m_wdata),
    .output_data   (output_data),
    .output_vector (output_vector),
    .vec_done      (vec_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  int          cyc = 0;
  int          done_cnt = 0;

  // Synchronous memory: one-cycle read latency, low 8 address bits select the word
  always @(posedge clk) begin
    mem_rdata <= mem[m_address[7:0]];
    if (m_wen) begin
      mem[m_address[7:0]] <= m_wdata;
      wa.push_back(m_address);
      wd.push_back(m_wdata);
      wc.push_back(cyc);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (vec_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issues one vector request and returns at the DONE cycle with the stall-cycle count
  task automatic vec_op(input logic st, input logic [31:0] a, input logic [31:0] s,
                        input logic [127:0] v, input logic drop, output int stall_n);
    int started;
    int fin;
    stall_n = 0;
    started = 0;
    fin     = 0;
    req          = 1'b1;
    is_vector    = 1'b1;
    mem_wen      = st;
    address      = a;
    stride       = s;
    input_vector = v;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall_cpu) begin
        stall_n++;
        started = 1;
      end else if (started != 0 && vec_done) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    check("vec_op_finished", 128'(fin), 128'd1);
    if (drop) begin
      req       = 1'b0;
      is_vector = 1'b0;
    end
  endtask

  int          sn;
  int          wn;
  int          dn;
  logic [127:0] vexp;

  initial begin
    rst          = 1'b0;
    req          = 1'b0;
    is_vector    = 1'b0;
    mem_wen      = 1'b0;
    address      = 32'h55;
    stride       = 32'h0;
    input_data   = 32'h66;
    input_vector = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_stall", 128'(stall_cpu), 128'd0);
    check("rst_m_wen", 128'(m_wen), 128'd0);
    check("rst_m_address", 128'(m_address), 128'h55);
    check("rst_m_wdata", 128'(m_wdata), 128'h66);
    check("rst_vec_done", 128'(vec_done), 128'd0);
    check("rst_output_vector", output_vector, 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // Unit-stride load
    preload(8'h10, 32'h11);
    preload(8'h11, 32'h22);
    preload(8'h12, 32'h33);
    preload(8'h13, 32'h44);
    dn = done_cnt;
    vec_op(1'b0, 32'h10, 32'd1, '0, 1'b1, sn);
    check("load1_stall_cycles", 128'(sn), 128'd6);
    check("load1_vector", output_vector, 128'h00000044_00000033_00000022_00000011);
    check("load1_done_pulses", 128'(done_cnt - dn), 128'd1);

    // Stride-2 store
    wn = wa.size();
    vec_op(1'b1, 32'h20, 32'd2, 128'h0000000D_0000000C_0000000B_0000000A, 1'b1, sn);
    check("st2_stall_cycles", 128'(sn), 128'd5);
    check("st2_write_count", 128'(wa.size() - wn), 128'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st2_addr%0d", i), 128'(wa[wn+i]), 128'(32'h20 + 2*i));
      check($sformatf("st2_data%0d", i), 128'(wd[wn+i]), 128'(32'hA + i));
    end
    check("st2_consecutive", 128'(wc[wn+3] - wc[wn]), 128'd3);

    // Stride-0 broadcast load
    preload(8'h40, 32'h5A);
    vec_op(1'b0, 32'h40, 32'd0, '0, 1'b1, sn);
    check("bcast_vector", output_vector, {4{32'h0000005A}});
    check("bcast_stall_cycles", 128'(sn), 128'd6);

    // Store with address wrap
    wn = wa.size();
    vec_op(1'b1, 32'hFFFFFFFE, 32'd1, 128'h4_00000003_00000002_00000001, 1'b1, sn);
    check("wrap_addr0", 128'(wa[wn+0]), 128'hFFFFFFFE);
    check("wrap_addr1", 128'(wa[wn+1]), 128'hFFFFFFFF);
    check("wrap_addr2", 128'(wa[wn+2]), 128'h0);
    check("wrap_addr3", 128'(wa[wn+3]), 128'h1);

    // Scalar store then load
    @(negedge clk);
    wn = wa.size();
    req        = 1'b1;
    is_vector  = 1'b0;
    mem_wen    = 1'b1;
    address    = 32'h8;
    input_data = 32'h1234;
    #1;
    check("sc_st_stall", 128'(stall_cpu), 128'd0);
    check("sc_st_m_wen", 128'(m_wen), 128'd1);
    check("sc_st_m_address", 128'(m_address), 128'h8);
    check("sc_st_m_wdata", 128'(m_wdata), 128'h1234);
    @(negedge clk);
    mem_wen    = 1'b0;
    input_data = 32'h0;
    #1;
    check("sc_ld_stall", 128'(stall_cpu), 128'd0);
    check("sc_ld_m_wen", 128'(m_wen), 128'd0);
    @(negedge clk);
    req = 1'b0;
    #1;
    check("sc_ld_output_data", 128'(output_data), 128'h1234);
    check("sc_write_count", 128'(wa.size() - wn), 128'd1);

    // Reset in the middle of a load
    @(negedge clk);
    dn = done_cnt;
    req       = 1'b1;
    is_vector = 1'b1;
    mem_wen   = 1'b0;
    address   = 32'h10;
    stride    = 32'd1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rml_lane0_before", 128'(output_vector[31:0]), 128'h11);
    rst = 1'b0;
    req = 1'b0;
    is_vector = 1'b0;
    #1;
    check("rml_stall", 128'(stall_cpu), 128'd0);
    check("rml_m_wen", 128'(m_wen), 128'd0);
    check("rml_output_vector", output_vector, 128'd0);
    wn = wa.size();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rml_no_writes", 128'(wa.size() - wn), 128'd0);
    check("rml_no_done", 128'(done_cnt - dn), 128'd0);
    check("rml_idle_stall", 128'(stall_cpu), 128'd0);
    vec_op(1'b0, 32'h10, 32'd1, '0, 1'b1, sn);
    check("rml_reload_stall", 128'(sn), 128'd6);
    check("rml_reload_vector", output_vector, 128'h00000044_00000033_00000022_00000011);

    // Back-to-back store then load with req held through DONE
    @(negedge clk);
    dn   = done_cnt;
    wn   = wa.size();
    vexp = 128'hCAFE0003_BEEF0002_DEAD0001_F00D0000;
    vec_op(1'b1, 32'h80, 32'd1, vexp, 1'b0, sn);
    check("b2b_store_stall", 128'(sn), 128'd5);
    vec_op(1'b0, 32'h80, 32'd1, '0, 1'b1, sn);
    check("b2b_load_stall", 128'(sn), 128'd6);
    check("b2b_vector", output_vector, vexp);
    check("b2b_writes", 128'(wa.size() - wn), 128'd4);
    repeat (3) @(negedge clk);
    #1;
    check("b2b_done_pulses", 128'(done_cnt - dn), 128'd2);
    check("b2b_idle_stall", 128'(stall_cpu), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
